// File: rtl/core_pkg.sv
// Shared definitions for the RV32 core front end: fetch state encoding and
// instruction-related constants.
package core_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam logic [31:0] INSTR_BYTES       = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2,
    S_DROP  = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] i_addr);
    return {i_addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/adder32.sv
// Plain 32-bit ripple-style adder with carry in/out; used as the PC incrementer.
module adder32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_cin};

endmodule

// File: rtl/fetch_stage.sv
// RV32 instruction fetch: single-outstanding imem requests, valid/ready
// hand-off to decode, and redirect/flush from execute.
//
// state   | meaning
// FETCH   | request pc on imem, wait for grant
// WAIT    | request granted, waiting for its response
// VALID   | instruction held for decode until accepted
// DROP    | a stale response is still owed; discard it on arrival
module fetch_stage
  import core_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic            r_inst_valid;

  logic [XLEN-1:0] w_pc_next_seq;
  logic [XLEN-1:0] w_redirect_pc;
  logic            w_sum_cout_unused;
  logic [1:0]      w_redirect_lsb_unused;

  adder32 u_pc_inc (
    .i_a    (r_pc),
    .i_b    (INSTR_BYTES),
    .i_cin  (1'b0),
    .o_sum  (w_pc_next_seq),
    .o_cout (w_sum_cout_unused)
  );

  assign w_redirect_pc         = word_align(redirect_pc);
  assign w_redirect_lsb_unused = redirect_pc[1:0];

  // Reset forces the state to FETCH, so the request must be masked by rst_n itself.
  assign imem_req   = rst_n && (r_state == S_FETCH);
  assign imem_addr  = r_pc;
  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_VEC;
      r_inst_valid <= 1'b0;
      r_inst       <= NOP_INSTR;
      r_inst_pc    <= RESET_VEC;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (redirect_valid) begin
            r_pc <= w_redirect_pc;
            if (imem_gnt) r_state <= S_DROP;
          end else if (imem_gnt) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect_valid) begin
            r_pc    <= w_redirect_pc;
            r_state <= imem_rvalid ? S_FETCH : S_DROP;
          end else if (imem_rvalid) begin
            r_inst       <= imem_rdata;
            r_inst_pc    <= r_pc;
            r_pc         <= w_pc_next_seq;
            r_inst_valid <= 1'b1;
            r_state      <= S_VALID;
          end
        end
        S_VALID: begin
          if (redirect_valid) begin
            r_pc         <= w_redirect_pc;
            r_inst_valid <= 1'b0;
            r_state      <= S_FETCH;
          end else if (inst_ready) begin
            r_inst_valid <= 1'b0;
            r_state      <= S_FETCH;
          end
        end
        S_DROP: begin
          if (redirect_valid) r_pc <= w_redirect_pc;
          // The owed response is consumed even if a redirect lands with it,
          // otherwise we would wait forever for a second one.
          if (imem_rvalid) r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand sequence for
// reset mid-fetch, and randomized memory/decode/redirect against a PC-stream model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
  } vec_t;

  function automatic vec_t mk(input logic gnt, input logic rv, input logic [31:0] rdata,
                              input logic rdy, input logic redir, input logic [31:0] rpc,
                              input logic e_req, input logic [31:0] e_addr, input logic e_v,
                              input logic [31:0] e_inst, input logic [31:0] e_ipc);
    vec_t v;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_v = e_v; v.e_inst = e_inst; v.e_ipc = e_ipc;
    return v;
  endfunction

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check_outs(input string tag, input logic req, input logic [31:0] addr,
                            input logic v, input logic [31:0] ins, input logic [31:0] ipc);
    check({tag, " req"}, 32'(imem_req), 32'(req));
    check({tag, " addr"}, imem_addr, addr);
    check({tag, " valid"}, 32'(inst_valid), 32'(v));
    check({tag, " inst"}, inst, ins);
    check({tag, " inst_pc"}, inst_pc, ipc);
  endtask

  task automatic drive_idle();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outs("reset", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
    rst_n = 1'b1;
  endtask

  vec_t tbl[$];

  initial begin
    // Directed cycle table: each row checks outputs, then drives that row's inputs.
    tbl.push_back(mk(1,0,0,0,0,0,                         1,32'h0,1'b0,NOP,32'h0));
    tbl.push_back(mk(0,1,32'h0050_0093,0,0,0,             0,32'h0,1'b0,NOP,32'h0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,0,0,0,0,                       0,32'h4,1'b1,32'h0050_0093,32'h0));
    tbl.push_back(mk(0,0,0,1,0,0,                         0,32'h4,1'b1,32'h0050_0093,32'h0));
    tbl.push_back(mk(1,0,0,0,0,0,                         1,32'h4,1'b0,32'h0050_0093,32'h0));
    tbl.push_back(mk(0,1,32'h0010_0113,0,0,0,             0,32'h4,1'b0,32'h0050_0093,32'h0));
    tbl.push_back(mk(0,0,0,1,0,0,                         0,32'h8,1'b1,32'h0010_0113,32'h4));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,0,0,0,0,                       1,32'h8,1'b0,32'h0010_0113,32'h4));
    tbl.push_back(mk(1,0,0,0,0,0,                         1,32'h8,1'b0,32'h0010_0113,32'h4));
    tbl.push_back(mk(0,0,0,0,0,0,                         0,32'h8,1'b0,32'h0010_0113,32'h4));
    tbl.push_back(mk(0,1,32'h0020_8193,0,0,0,             0,32'h8,1'b0,32'h0010_0113,32'h4));
    tbl.push_back(mk(0,0,0,1,0,0,                         0,32'hC,1'b1,32'h0020_8193,32'h8));
    tbl.push_back(mk(1,0,0,0,0,0,                         1,32'hC,1'b0,32'h0020_8193,32'h8));
    tbl.push_back(mk(0,0,0,0,1,32'h100,                   0,32'hC,1'b0,32'h0020_8193,32'h8));
    tbl.push_back(mk(0,0,0,0,0,0,                         0,32'h100,1'b0,32'h0020_8193,32'h8));
    tbl.push_back(mk(0,1,32'hDEAD_BEEF,0,0,0,             0,32'h100,1'b0,32'h0020_8193,32'h8));
    tbl.push_back(mk(1,0,0,0,0,0,                         1,32'h100,1'b0,32'h0020_8193,32'h8));
    tbl.push_back(mk(0,1,32'h4000_0033,0,0,0,             0,32'h100,1'b0,32'h0020_8193,32'h8));
    tbl.push_back(mk(0,0,0,1,0,0,                         0,32'h104,1'b1,32'h4000_0033,32'h100));
    tbl.push_back(mk(1,0,0,0,0,0,                         1,32'h104,1'b0,32'h4000_0033,32'h100));
    tbl.push_back(mk(0,1,32'hDEAD_BEEF,0,1,32'h203,       0,32'h104,1'b0,32'h4000_0033,32'h100));
    tbl.push_back(mk(1,0,0,0,0,0,                         1,32'h200,1'b0,32'h4000_0033,32'h100));
    tbl.push_back(mk(0,1,32'h0030_0213,0,0,0,             0,32'h200,1'b0,32'h4000_0033,32'h100));
    tbl.push_back(mk(0,0,0,1,1,32'hFFFF_FFFC,             0,32'h204,1'b1,32'h0030_0213,32'h200));
    tbl.push_back(mk(1,0,0,0,0,0,                         1,32'hFFFF_FFFC,1'b0,32'h0030_0213,32'h200));
    tbl.push_back(mk(0,1,32'h1111_1113,0,0,0,             0,32'hFFFF_FFFC,1'b0,32'h0030_0213,32'h200));
    tbl.push_back(mk(0,0,0,1,0,0,                         0,32'h0,1'b1,32'h1111_1113,32'hFFFF_FFFC));
    tbl.push_back(mk(1,0,0,0,0,0,                         1,32'h0,1'b0,32'h1111_1113,32'hFFFF_FFFC));
    tbl.push_back(mk(0,1,32'h2222_2213,0,0,0,             0,32'h0,1'b0,32'h1111_1113,32'hFFFF_FFFC));
    tbl.push_back(mk(0,0,0,1,0,0,                         0,32'h4,1'b1,32'h2222_2213,32'h0));
    tbl.push_back(mk(0,0,0,0,1,32'h300,                   1,32'h4,1'b0,32'h2222_2213,32'h0));
    tbl.push_back(mk(1,0,0,0,1,32'h400,                   1,32'h300,1'b0,32'h2222_2213,32'h0));
    tbl.push_back(mk(0,1,32'hDEAD_BEEF,0,0,0,             0,32'h400,1'b0,32'h2222_2213,32'h0));
    tbl.push_back(mk(0,0,0,0,0,0,                         1,32'h400,1'b0,32'h2222_2213,32'h0));

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      check_outs($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_v,
                 tbl[i].e_inst, tbl[i].e_ipc);
      imem_gnt       = tbl[i].gnt;
      imem_rvalid    = tbl[i].rv;
      imem_rdata     = tbl[i].rdata;
      inst_ready     = tbl[i].rdy;
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
    end

    // Reset asserted while WAIT, then a late response arriving in FETCH.
    @(negedge clk);
    drive_idle();
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    check("rst7 in wait req", 32'(imem_req), 32'h0);
    #2 rst_n = 1'b0;
    #1 check_outs("rst7 async", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    check_outs("rst7 late rvalid", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
    imem_rvalid = 1'b0;
    imem_gnt    = 1'b1;
    @(negedge clk);
    check("rst7 wait req", 32'(imem_req), 32'h0);
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h3333_3313;
    @(negedge clk);
    check_outs("rst7 first fetch", 1'b0, 32'h4, 1'b1, 32'h3333_3313, 32'h0);
    drive_idle();

    // Randomized run: bench models memory and checks the delivered PC stream.
    begin
      logic [31:0] exp_pc;
      logic        pend;
      logic [31:0] paddr;
      int          cnt;
      int          handoffs;
      logic        have_prev;
      logic        p_req, p_gnt, p_redir, p_v, p_rdy;
      logic [31:0] p_addr, p_inst, p_ipc;
      logic        rv, real_rv, gnt, rdy, redir;
      logic [31:0] rdata, rpc;

      do_reset();
      exp_pc = 32'h0; pend = 1'b0; paddr = 32'h0; cnt = 0; handoffs = 0;
      have_prev = 1'b0;
      p_req = 0; p_gnt = 0; p_redir = 0; p_v = 0; p_rdy = 0;
      p_addr = 0; p_inst = 0; p_ipc = 0;

      for (int c = 0; c < 3000; c++) begin
        @(negedge clk);
        if (imem_req) begin
          check("rnd addr aligned", {30'd0, imem_addr[1:0]}, 32'h0);
          check("rnd single outstanding", 32'(pend), 32'h0);
        end
        if (have_prev && p_req && !p_gnt && !p_redir) begin
          check("rnd req held", 32'(imem_req), 32'h1);
          check("rnd addr held", imem_addr, p_addr);
        end
        if (have_prev && p_v && !p_rdy && !p_redir) begin
          check("rnd valid held", 32'(inst_valid), 32'h1);
          check("rnd inst held", inst, p_inst);
          check("rnd inst_pc held", inst_pc, p_ipc);
        end

        real_rv = pend && (cnt == 0);
        if (real_rv) begin
          rv    = 1'b1;
          rdata = memfn(paddr);
          pend  = 1'b0;
        end else begin
          if (pend) cnt--;
          rv    = !pend && ($urandom_range(0, 7) == 0);
          rdata = 32'hBAD0_0000 | ($urandom & 32'h0000_FFFF);
        end
        gnt   = ($urandom_range(0, 3) != 0);
        rdy   = ($urandom_range(0, 2) != 0);
        redir = !real_rv && ($urandom_range(0, 9) == 0);
        rpc   = $urandom;

        if (inst_valid && rdy) begin
          check("rnd handoff pc", inst_pc, exp_pc);
          check("rnd handoff inst", inst, memfn(exp_pc));
          exp_pc = exp_pc + 32'd4;
          handoffs++;
        end
        if (redir) exp_pc = {rpc[31:2], 2'b00};
        if (imem_req && gnt) begin
          pend  = 1'b1;
          paddr = imem_addr;
          cnt   = $urandom_range(0, 3);
        end

        p_req = imem_req; p_gnt = gnt; p_redir = redir; p_addr = imem_addr;
        p_v = inst_valid; p_rdy = rdy; p_inst = inst; p_ipc = inst_pc;
        have_prev = 1'b1;

        imem_gnt       = gnt;
        imem_rvalid    = rv;
        imem_rdata     = rdata;
        inst_ready     = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
      end
      check("rnd progress", 32'(handoffs > 100), 32'h1);
    end

    drive_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
